// File: rtl/fetch_queue_if.sv
// Instruction-memory port of the fetch stage, seen from the fetch side (master) and the memory (slave).
// Handshake: a request transfers at posedge when ImemReq && ImemGnt; until then ImemReq/ImemAddr may
// drop or change. Each transferred request is answered by one ImemRspVal cycle, at least one cycle later.
interface fetch_queue_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRspVal;
  logic [31:0] ImemRspData;

  modport master (output ImemReq, ImemAddr, input ImemGnt, ImemRspVal, ImemRspData);
  modport slave  (input ImemReq, ImemAddr, output ImemGnt, ImemRspVal, ImemRspData);
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: one outstanding imem request, a small FIFO of returned words,
// and squashing of stale words on decode jumps and EX branch redirects.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 AnyStall,
  input  logic                 Jump_IDM1,
  input  logic [25:0]          JumpTgt_IDM1,
  input  logic                 ExRedirect_EX,
  input  logic [31:0]          ExRedirectPc_EX,
  fetch_queue_if.master        imem,
  output logic [31:0]          Pc_IF,
  output logic [31:0]          FetchData_IF,
  output logic                 InstrVal_IF
);

  localparam int            PW      = $clog2(FQ_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   out_pc;
  logic          outstanding;
  logic          discard;
  logic          run;

  logic [31:0]   pc_q   [FQ_DEPTH];
  logic [31:0]   data_q [FQ_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic          jump;
  logic          redirect_any;
  logic          grant;
  logic          rsp;
  logic          push;
  logic [31:0]   pc_plus4;
  logic [31:0]   jump_pc;
  logic [31:0]   redirect_pc;

  assign InstrVal_IF  = (count != '0);
  assign Pc_IF        = pc_q[rd_ptr];
  assign FetchData_IF = data_q[rd_ptr];

  assign pop          = InstrVal_IF && !AnyStall;
  assign jump         = Jump_IDM1 && pop;
  assign redirect_any = ExRedirect_EX || jump;

  // run holds off the first request until the cycle after reset release.
  assign imem.ImemReq  = run && !outstanding && (count < DEPTH_C);
  assign imem.ImemAddr = fpc;
  assign grant         = imem.ImemReq && imem.ImemGnt;
  assign rsp           = outstanding && imem.ImemRspVal;
  assign push          = rsp && !discard && !redirect_any;

  assign pc_plus4    = Pc_IF + 32'd4;
  assign jump_pc     = (pc_plus4 & 32'hF000_0000) | {4'b0000, JumpTgt_IDM1, 2'b00};
  assign redirect_pc = ExRedirectPc_EX & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run         <= 1'b0;
      fpc         <= RESET_PC;
      out_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      run <= 1'b1;

      if (grant) begin
        outstanding <= 1'b1;
        out_pc      <= fpc;
      end else if (rsp) begin
        outstanding <= 1'b0;
      end

      // A grant in a redirect cycle fetched the old stream, so the target wins over fpc+4.
      if (ExRedirect_EX)  fpc <= redirect_pc;
      else if (jump)      fpc <= jump_pc;
      else if (grant)     fpc <= fpc + 32'd4;

      if (redirect_any)   discard <= (outstanding && !imem.ImemRspVal) || grant;
      else if (rsp)       discard <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        pc_q[i]   <= '0;
        data_q[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_any) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]   <= out_pc;
        data_q[wr_ptr] <= imem.ImemRspData;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: memory and decode models run at negedge; every valid head is checked
// against the program-order PC stream the bench predicts from reset, jumps and redirects.
module tb_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        AnyStall = 1'b0;
  logic        Jump_IDM1 = 1'b0;
  logic [25:0] JumpTgt_IDM1 = '0;
  logic        ExRedirect_EX = 1'b0;
  logic [31:0] ExRedirectPc_EX = '0;
  logic [31:0] Pc_IF;
  logic [31:0] FetchData_IF;
  logic        InstrVal_IF;

  fetch_queue_if imem ();

  fetch_queue #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .AnyStall        (AnyStall),
    .Jump_IDM1       (Jump_IDM1),
    .JumpTgt_IDM1    (JumpTgt_IDM1),
    .ExRedirect_EX   (ExRedirect_EX),
    .ExRedirectPc_EX (ExRedirectPc_EX),
    .imem            (imem),
    .Pc_IF           (Pc_IF),
    .FetchData_IF    (FetchData_IF),
    .InstrVal_IF     (InstrVal_IF)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // stimulus knobs
  int mem_lat   = 1;    // 0 selects a random latency 1..4 per request
  int gnt_pct   = 100;
  int stall_pct = 0;
  int jump_pct  = 0;
  int redir_pct = 0;
  logic [31:0] data_key = '0;
  logic [31:0] j_addr   = 32'hFFFF_FFFF;
  logic [31:0] j_word   = '0;
  logic        inject   = 1'b0;
  logic [31:0] inject_data = '0;
  logic        redir_now = 1'b0;
  logic        jump_too  = 1'b0;
  logic [31:0] redir_pc  = '0;

  // memory model state
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;

  // reference model and scoreboard
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_q[$];
  int          npops = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == j_addr) return j_word;
    return a ^ data_key;
  endfunction

  initial begin
    imem.ImemGnt     = 1'b0;
    imem.ImemRspVal  = 1'b0;
    imem.ImemRspData = '0;
  end

  // driver: one clock of memory and decode behaviour, applied at negedge
  task automatic step();
    logic        busy_before;
    logic        do_redir;
    logic        do_jump;
    logic [25:0] tgt;
    logic [31:0] pc4;
    logic [31:0] e;
    @(negedge clk);
    if (reset) begin
      mem_busy = 1'b0;
      imem.ImemRspVal = 1'b0;
      imem.ImemGnt = 1'b0;
      AnyStall = 1'b0;
      Jump_IDM1 = 1'b0;
      ExRedirect_EX = 1'b0;
      return;
    end
    busy_before = mem_busy;
    imem.ImemRspVal  = 1'b0;
    imem.ImemRspData = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem.ImemRspVal  = 1'b1;
        imem.ImemRspData = mem_word(mem_addr);
        mem_busy = 1'b0;
      end
    end else if (inject) begin
      imem.ImemRspVal  = 1'b1;
      imem.ImemRspData = inject_data;
    end
    imem.ImemGnt = (int'($urandom_range(0, 99)) < gnt_pct);
    if (imem.ImemReq) begin
      checks++;
      if (busy_before || imem.ImemAddr[1:0] != 2'b00) begin
        fails++;
        $display("FAIL imem_req: req with pending=%0b addr=%h, required no pending and aligned addr", busy_before, imem.ImemAddr);
      end
      if (imem.ImemGnt) begin
        mem_busy = 1'b1;
        mem_addr = imem.ImemAddr;
        mem_cnt  = (mem_lat == 0) ? int'($urandom_range(1, 4)) : mem_lat;
      end
    end

    AnyStall = (int'($urandom_range(0, 99)) < stall_pct);
    Jump_IDM1 = 1'b0;
    ExRedirect_EX = 1'b0;
    JumpTgt_IDM1 = 26'($urandom);
    ExRedirectPc_EX = $urandom;
    do_redir = (redir_pct > 0) && (int'($urandom_range(0, 99)) < redir_pct);
    if (redir_now || do_redir) begin
      ExRedirect_EX = 1'b1;
      ExRedirectPc_EX = redir_now ? redir_pc : {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom)};
      if (jump_too) begin
        AnyStall = 1'b0;
        Jump_IDM1 = 1'b1;
        JumpTgt_IDM1 = 26'h10;
      end
      exp_pc = {ExRedirectPc_EX[31:2], 2'b00};
      redir_now = 1'b0;
      jump_too = 1'b0;
    end else if (InstrVal_IF === 1'b1) begin
      checks++;
      if (Pc_IF !== exp_pc || FetchData_IF !== mem_word(exp_pc)) begin
        fails++;
        $display("FAIL head: Pc_IF=%h FetchData_IF=%h, required Pc_IF=%h FetchData_IF=%h", Pc_IF, FetchData_IF, exp_pc, mem_word(exp_pc));
      end
      if (!AnyStall) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if (Pc_IF !== e) begin
            fails++;
            $display("FAIL pop_seq: popped Pc_IF=%h, required %h", Pc_IF, e);
          end
        end
        npops++;
        do_jump = (exp_pc == j_addr) || (int'($urandom_range(0, 99)) < jump_pct);
        if (do_jump) begin
          tgt = (exp_pc == j_addr) ? j_word[25:0] : 26'($urandom);
          Jump_IDM1 = 1'b1;
          JumpTgt_IDM1 = tgt;
          pc4 = exp_pc + 32'd4;
          exp_pc = {pc4[31:28], tgt, 2'b00};
        end else begin
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected pops still outstanding after %0d cycles, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (imem.ImemReq !== 1'b0 || InstrVal_IF !== 1'b0 || Pc_IF !== 32'h0 || FetchData_IF !== 32'h0 || imem.ImemAddr !== RESET_PC) begin
      fails++;
      $display("FAIL reset_outputs: req=%b val=%b pc=%h data=%h addr=%h, required 0 0 0 0 %h",
               imem.ImemReq, InstrVal_IF, Pc_IF, FetchData_IF, imem.ImemAddr, RESET_PC);
    end
  endtask

  task automatic test_basic_fetch();
    data_key = '0; mem_lat = 1; gnt_pct = 100; stall_pct = 0;
    exp_pc = RESET_PC; npops = 0;
    exp_q = '{32'h0, 32'h4, 32'h8};
    @(posedge clk); #1 reset = 1'b0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      step();
      if (cyc <= 3) begin
        checks++;
        if (imem.ImemReq !== (cyc == 1 || cyc == 3) || InstrVal_IF !== (cyc == 3)) begin
          fails++;
          $display("FAIL startup_latency: cycle %0d req=%b val=%b, required req=%0b val=%0b",
                   cyc, imem.ImemReq, InstrVal_IF, (cyc == 1 || cyc == 3), (cyc == 3));
        end
      end
    end
    checks++;
    if (npops != 3) begin
      fails++;
      $display("FAIL throughput: %0d pops in cycles 0..8, required 3", npops);
    end
    drain(20, "basic_fetch");
  endtask

  task automatic test_stall_full();
    stall_pct = 100;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (imem.ImemReq !== 1'b0 || InstrVal_IF !== 1'b1 || mem_busy) begin
        fails++;
        $display("FAIL stall_full: req=%b val=%b pending=%0b, required 0 1 0", imem.ImemReq, InstrVal_IF, mem_busy);
      end
    end
    stall_pct = 0;
    exp_q = '{exp_pc, exp_pc + 32'd4, exp_pc + 32'd8};
    drain(30, "stall_release");
  endtask

  task automatic test_jump();
    j_addr = 32'h100; j_word = 32'h0800_0010;
    redir_pc = 32'hF8; redir_now = 1'b1;
    exp_q = '{32'hF8, 32'hFC, 32'h100, 32'h40, 32'h44};
    drain(60, "jump");
    j_addr = 32'hFFFF_FFFF;
  endtask

  task automatic test_ex_redirect();
    int found = 0;
    mem_lat = 3;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (mem_busy && mem_cnt == 3) found = 1;
    end
    checks++;
    if (found == 0) begin
      fails++;
      $display("FAIL redirect_setup: no grant seen within 40 cycles, required one");
    end
    redir_pc = 32'h200; redir_now = 1'b1;
    exp_q = '{32'h200, 32'h204};
    drain(60, "ex_redirect");
    mem_lat = 1;
  endtask

  task automatic test_wrap();
    mem_lat = 0; gnt_pct = 70;
    data_key = $urandom;
    redir_pc = 32'hFFFF_FFF9; redir_now = 1'b1;
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
    drain(100, "pc_wrap");
    mem_lat = 1; gnt_pct = 100;
  endtask

  task automatic test_jump_and_redirect();
    int found = 0;
    stall_pct = 100;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step();
      if (InstrVal_IF === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin
      fails++;
      $display("FAIL jump_redirect_setup: head never valid in 20 cycles, required valid");
    end
    stall_pct = 0;
    redir_pc = 32'h300; redir_now = 1'b1; jump_too = 1'b1;
    exp_q = '{32'h300, 32'h304};
    drain(40, "jump_and_redirect");
  endtask

  task automatic test_random();
    mem_lat = 0; gnt_pct = 70; stall_pct = 30; jump_pct = 10; redir_pct = 3;
    npops = 0;
    for (int i = 0; i < 800; i++) step();
    checks++;
    if (npops < 50) begin
      fails++;
      $display("FAIL random_progress: %0d pops in 800 cycles, required at least 50", npops);
    end
    gnt_pct = 100; stall_pct = 0; jump_pct = 0; redir_pct = 0; mem_lat = 1;
  endtask

  task automatic test_mid_reset();
    int found = 0;
    mem_lat = 3;
    for (int i = 0; i < 40 && found == 0; i++) begin
      step();
      if (mem_busy) found = 1;
    end
    #2 reset = 1'b1;
    step();
    step();
    checks++;
    if (found == 0 || imem.ImemReq !== 1'b0 || InstrVal_IF !== 1'b0 || Pc_IF !== 32'h0 || FetchData_IF !== 32'h0) begin
      fails++;
      $display("FAIL mid_reset: pending_seen=%0d req=%b val=%b pc=%h data=%h, required 1 0 0 0 0",
               found, imem.ImemReq, InstrVal_IF, Pc_IF, FetchData_IF);
    end
    mem_lat = 1; exp_pc = RESET_PC;
    exp_q = '{32'h0, 32'h4, 32'h8};
    @(posedge clk); #1 reset = 1'b0;
    inject = 1'b1; inject_data = 32'hDEAD_BEEF;
    for (int cyc = 0; cyc < 4; cyc++) begin
      step();
      inject = 1'b0;
      checks++;
      if (imem.ImemReq !== (cyc == 1 || cyc == 3) || InstrVal_IF !== (cyc == 3)) begin
        fails++;
        $display("FAIL late_rsp_ignored: cycle %0d req=%b val=%b, required req=%0b val=%0b",
                 cyc, imem.ImemReq, InstrVal_IF, (cyc == 1 || cyc == 3), (cyc == 3));
      end
    end
    drain(20, "restart_after_reset");
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_stall_full();
    test_jump();
    test_ex_redirect();
    test_wrap();
    test_jump_and_redirect();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
